// File: rtl/mux_sel_pkg.sv
// Shared state encoding and owner constants for the two-input mux select arbiter.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter_hold_counter.sv
// Saturating ownership dwell counter; clear has priority over enable.
module hold_counter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CW'(MAX_HOLD))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin two-requester arbiter driving the mux select with a minimum dwell.
// Define MUX_SEL_ARBITER_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles under contention.
module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    output logic sl,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic switch_pulse
);

    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    state_e        state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic          sl_q, sl_d;
    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic          busy_q, busy_d;
    logic          switch_pulse_q, switch_pulse_d;
    logic [CW-1:0] cnt;
    logic          cnt_clear;
    logic          cnt_en;
    logic          hold_met;
    logic          entering;
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
    logic          timeout;
    assign timeout = (cnt == CW'(MAX_HOLD - 1));
`endif

    assign hold_met = (cnt >= CW'(HOLD_CYCLES - 1));

    hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .CW       (CW)
    ) u_hold_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cnt)
    );

    always_comb begin
        state_d        = state_q;
        last_owner_d   = last_owner_q;
        sl_d           = sl_q;
        entering       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = (last_owner_q == SEL_A) ? OWN_B : OWN_A;
                end else if (req_a) begin
                    state_d = OWN_A;
                end else if (req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (hold_met && !req_a) begin
                    state_d = req_b ? OWN_B : IDLE;
                end
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
                if (timeout && req_b) begin
                    state_d = OWN_B;
                end
`endif
            end
            OWN_B: begin
                if (hold_met && !req_b) begin
                    state_d = req_a ? OWN_A : IDLE;
                end
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
                if (timeout && req_a) begin
                    state_d = OWN_A;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // A new ownership (from IDLE or a direct handoff) restarts the dwell.
        entering = (state_d != IDLE) && (state_d != state_q);
        if (entering) begin
            last_owner_d = (state_d == OWN_B) ? SEL_B : SEL_A;
        end

        if (state_d == OWN_A) begin
            sl_d = SEL_A;
        end else if (state_d == OWN_B) begin
            sl_d = SEL_B;
        end

        gnt_a_d        = (state_d == OWN_A);
        gnt_b_d        = (state_d == OWN_B);
        busy_d         = gnt_a_d || gnt_b_d;
        switch_pulse_d = (sl_d != sl_q);
    end

    assign cnt_clear = entering;
    assign cnt_en    = (state_q != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            last_owner_q   <= SEL_B;
            sl_q           <= SEL_A;
            gnt_a_q        <= 1'b0;
            gnt_b_q        <= 1'b0;
            busy_q         <= 1'b0;
            switch_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            sl_q           <= sl_d;
            gnt_a_q        <= gnt_a_d;
            gnt_b_q        <= gnt_b_d;
            busy_q         <= busy_d;
            switch_pulse_q <= switch_pulse_d;
        end
    end

    assign sl           = sl_q;
    assign gnt_a        = gnt_a_q;
    assign gnt_b        = gnt_b_q;
    assign busy         = busy_q;
    assign switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Randomized and directed bench for mux_sel_arbiter against a dwell-based reference model.
module tb_mux_sel_arbiter;

    localparam int HOLD = 4;
    localparam int MAXH = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req_a = 1'b0;
    logic req_b = 1'b0;
    logic sl, gnt_a, gnt_b, busy, switch_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: owner 0=none,1=A,2=B; dwell = cycles owned so far.
    int owner, dwell, last;
    bit sl_m, sp_m;

    mux_sel_arbiter #(.HOLD_CYCLES(HOLD), .MAX_HOLD(MAXH)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_a        (req_a),
        .req_b        (req_b),
        .sl           (sl),
        .gnt_a        (gnt_a),
        .gnt_b        (gnt_b),
        .busy         (busy),
        .switch_pulse (switch_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0; dwell = 0; last = 2; sl_m = 1'b0; sp_m = 1'b0;
    endtask

    task automatic model_edge(input bit ra, input bit rb);
        int nxt;
        bit mine, other, new_sl;
        nxt = owner;
        if (owner == 0) begin
            if (ra && rb) nxt = (last == 1) ? 2 : 1;
            else if (ra)  nxt = 1;
            else if (rb)  nxt = 2;
        end else begin
            mine  = (owner == 1) ? ra : rb;
            other = (owner == 1) ? rb : ra;
            if (dwell >= HOLD && !mine) nxt = other ? 3 - owner : 0;
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
            if (dwell == MAXH && other) nxt = 3 - owner;
`endif
        end
        if (nxt != 0 && nxt != owner) begin
            dwell = 1;
            last  = nxt;
        end else if (nxt != 0) begin
            dwell++;
        end
        owner  = nxt;
        new_sl = (owner == 1) ? 1'b0 : (owner == 2) ? 1'b1 : sl_m;
        sp_m   = (new_sl != sl_m);
        sl_m   = new_sl;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".sl"},    int'(sl),           int'(sl_m));
        chk({tag, ".gnt_a"}, int'(gnt_a),        int'(owner == 1));
        chk({tag, ".gnt_b"}, int'(gnt_b),        int'(owner == 2));
        chk({tag, ".busy"},  int'(busy),         int'(owner != 0));
        chk({tag, ".swp"},   int'(switch_pulse), int'(sp_m));
    endtask

    // Drive requests for one cycle, advance one edge, compare after the edge.
    task automatic step(input bit ra, input bit rb, input string tag);
        req_a = ra;
        req_b = rb;
        @(posedge clock);
        model_edge(ra, rb);
        #1;
        check_outputs(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".sl"},    int'(sl),           0);
        chk({tag, ".gnt_a"}, int'(gnt_a),        0);
        chk({tag, ".gnt_b"}, int'(gnt_b),        0);
        chk({tag, ".busy"},  int'(busy),         0);
        chk({tag, ".swp"},   int'(switch_pulse), 0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    initial begin
        int a_cycles, b_cycles, first_a, ga_rise, gb_rise;
        bit pa;
        model_reset();
        #1;
        check_zero("rst_init");
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;

        // Single-cycle request from A: full dwell, then idle, sl never moves.
        a_cycles = 0;
        step(1'b1, 1'b0, "a_pulse");
        if (gnt_a) a_cycles++;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, "a_pulse");
            if (gnt_a) a_cycles++;
        end
        chk("a_pulse_len", a_cycles, HOLD);

        // Simultaneous request after reset: A first, then direct handoff to B.
        do_reset();
        step(1'b1, 1'b1, "both");
        chk("both_first_a", int'(gnt_a), 1);
        for (int i = 0; i < HOLD - 1; i++) step(1'b1, 1'b1, "both");
        step(1'b0, 1'b1, "handoff");
        chk("handoff_b", int'(gnt_b), 1);
        chk("handoff_pulse", int'(switch_pulse), 1);
        for (int i = 0; i < HOLD - 1; i++) step(1'b0, 1'b1, "b_own");
        step(1'b0, 1'b0, "b_rel");

        // Repeated contention alternates owners.
        first_a = -1;
        for (int r = 0; r < 10; r++) begin
            step(1'b1, 1'b1, "rr");
            if (r == 0) first_a = int'(gnt_a);
            chk("rr_alt", int'(gnt_a), (r % 2 == 0) ? 1 : 0);
            for (int i = 0; i < HOLD - 1; i++) step(1'b1, 1'b1, "rr");
            step(1'b0, 1'b0, "rr_gap");
        end
        chk("rr_first_a", first_a, 1);

        // A held with B contending.
        do_reset();
        ga_rise = -1;
        gb_rise = -1;
        b_cycles = 0;
        pa = 1'b0;
        for (int t = 0; t < 100; t++) begin
            step(1'b1, 1'b1, "hold_a");
            if (gnt_a && !pa) ga_rise = t;
            if (gnt_b && gb_rise < 0) gb_rise = t;
            if (gnt_b) b_cycles++;
            pa = gnt_a;
        end
`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
        chk("timeout_delay", gb_rise - ga_rise, MAXH);
`else
        chk("no_preempt", b_cycles, 0);
`endif

        // Reset while B owns, then B alone re-acquires with a select switch.
        do_reset();
        step(1'b0, 1'b1, "own_b");
        step(1'b0, 1'b1, "own_b");
        chk("own_b_gnt", int'(gnt_b), 1);
        do_reset();
        step(1'b0, 1'b1, "post_rst_b");
        chk("post_rst_sl", int'(sl), 1);
        chk("post_rst_pulse", int'(switch_pulse), 1);

        // Random traffic with sticky requests.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            bit ra, rb;
            ra = ($urandom_range(0, 3) != 0) ? req_a : 1'($urandom_range(0, 1));
            rb = ($urandom_range(0, 3) != 0) ? req_b : 1'($urandom_range(0, 1));
            step(ra, rb, "rand");
            if (gnt_a && gnt_b) chk("onehot", 1, 0);
            if (t % 997 == 500) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
